calc_seq_alu: RTL and testbench

- Next-generation calculator core: parametrised width, registered results, valid/ready handshake on both sides.
- Extends the 4-op, 4-bit combinational calculator with AND, XOR, an iterative multiply, an accumulate mode and status flags.
- Result nibble drives a seven-segment decoder for the board display.
- Sits between the operand/op front end (switches or GUI bridge) and the result/display logic.

---
 rtl/calc_seq_alu.sv | 209 ++++++++++++++++++++
 tb/tb_calc_seq_alu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_alu.sv
// Sequential calculator core: registered ALU with an iterative shift-add multiplier,
// an accumulator, status flags and a seven-segment decode of one result nibble.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for a request
// MUL    | shift-add multiply, one multiplier bit per cycle
// DONE   | out_valid=1, result held until out_ready
module calc_seq_alu #(
    parameter int WIDTH      = 8,
    parameter int SEG_NIBBLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic [6:0]       seven_output
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ACC = 3'b111;

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     acc_q, acc_d;

    logic [WIDTH:0]       add_ext, sub_ext, acc_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [2*WIDTH-1:0]   prod_step;

    // Single-cycle ALU operates directly on the live inputs at the accept edge.
    always_comb begin
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} - {1'b0, b};
        acc_ext = {1'b0, acc_q} + {1'b0, a};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  alu_res = a | b;
            OP_NEG: begin
                alu_res = (~a) + ONE;
                alu_v   = (a == MIN_NEG);
            end
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_ACC: begin
                alu_res = acc_ext[WIDTH-1:0];
                alu_c   = acc_ext[WIDTH];
                alu_v   = (acc_q[WIDTH-1] == a[WIDTH-1]) && (acc_ext[WIDTH-1] != acc_q[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = CNT_LAST;
                        state_d  = S_MUL;
                    end else begin
                        res_d   = alu_res;
                        carry_d = alu_c;
                        ovf_d   = alu_v;
                        zero_d  = (alu_res == '0);
                        acc_d   = alu_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                // Last multiplier bit: publish the truncated product directly.
                if (cnt_q == '0) begin
                    res_d   = prod_step[WIDTH-1:0];
                    carry_d = 1'b0;
                    ovf_d   = |prod_step[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_step[WIDTH-1:0] == '0);
                    acc_d   = prod_step[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    logic [3:0] seg_nib;
    assign seg_nib = res_q[4*SEG_NIBBLE +: 4];

    always_comb begin
        seven_output = 7'h3F;
        case (seg_nib)
            4'h0: seven_output = 7'h3F;
            4'h1: seven_output = 7'h06;
            4'h2: seven_output = 7'h5B;
            4'h3: seven_output = 7'h4F;
            4'h4: seven_output = 7'h66;
            4'h5: seven_output = 7'h6D;
            4'h6: seven_output = 7'h7D;
            4'h7: seven_output = 7'h07;
            4'h8: seven_output = 7'h7F;
            4'h9: seven_output = 7'h6F;
            4'hA: seven_output = 7'h77;
            4'hB: seven_output = 7'h7C;
            4'hC: seven_output = 7'h39;
            4'hD: seven_output = 7'h5E;
            4'hE: seven_output = 7'h79;
            4'hF: seven_output = 7'h71;
            default: seven_output = 7'h3F;
        endcase
    end

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed bench for calc_seq_alu (WIDTH=8): an arithmetic model pushes expected results
// into a scoreboard queue at request time; they are popped when out_valid rises.
module tb_calc_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic [6:0] seven_output;

    calc_seq_alu #(.WIDTH(8), .SEG_NIBBLE(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .res          (res),
        .carry        (carry),
        .overflow     (overflow),
        .zero         (zero),
        .seven_output (seven_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        int         lat;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc;
    int         n_total;
    int         n_pass;
    int         n_fail;
    logic [6:0] segtab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int sext(input logic [7:0] x);
        return (x >= 8'd128) ? int'(x) - 256 : int'(x);
    endfunction

    // Model computes expected result and drives the request (held until accepted).
    task automatic start(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input string tag);
        exp_t e;
        int   p;
        int   sr;
        e.c = 1'b0;
        e.v = 1'b0;
        e.r = 8'h00;
        case (o)
            3'd0: begin
                p = int'(x) + int'(y); e.r = p[7:0]; e.c = (p > 255);
                sr = sext(x) + sext(y); e.v = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                p = int'(x) - int'(y); e.r = p[7:0]; e.c = (x < y);
                sr = sext(x) - sext(y); e.v = (sr > 127) || (sr < -128);
            end
            3'd2: e.r = x | y;
            3'd3: begin
                p = 256 - int'(x); e.r = p[7:0]; e.v = (x == 8'h80);
            end
            3'd4: e.r = x & y;
            3'd5: e.r = x ^ y;
            3'd6: begin
                p = int'(x) * int'(y); e.r = p[7:0]; e.v = (p > 255);
            end
            default: begin
                p = int'(m_acc) + int'(x); e.r = p[7:0]; e.c = (p > 255);
                sr = sext(m_acc) + sext(x); e.v = (sr > 127) || (sr < -128);
            end
        endcase
        e.z   = (e.r == 8'h00);
        e.lat = (o == 3'd6) ? 9 : 1;
        e.tag = tag;
        m_acc = e.r;
        sb.push_back(e);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
    endtask

    // Called at the negedge right after the accept edge.
    task automatic wait_result();
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_out_valid"}, 32'(out_valid), 32'd1);
            chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({e.tag, "_res"}, 32'(res), 32'(e.r));
            chk({e.tag, "_carry"}, 32'(carry), 32'(e.c));
            chk({e.tag, "_overflow"}, 32'(overflow), 32'(e.v));
            chk({e.tag, "_zero"}, 32'(zero), 32'(e.z));
            chk({e.tag, "_seven"}, 32'(seven_output), 32'(segtab[e.r[3:0]]));
            chk({e.tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_out_valid", 32'(out_valid), 32'd0);
        chk("consume_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input string tag);
        start(o, x, y, tag);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = 8'($urandom);
        b  = 8'($urandom);
        wait_result();
        consume();
    endtask

    initial begin
        segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        n_total   = 0;
        n_pass    = 0;
        n_fail    = 0;
        m_acc     = 8'h00;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 8'h00;
        b         = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_flags", {29'd0, carry, overflow, zero}, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_seven", 32'(seven_output), 32'h3F);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        do_op(3'd0, 8'hF0, 8'h20, "add_f0_20");
        do_op(3'd1, 8'h05, 8'h07, "sub_05_07");
        do_op(3'd1, 8'h80, 8'h01, "sub_80_01");
        do_op(3'd3, 8'h80, 8'h00, "neg_80");
        do_op(3'd3, 8'h00, 8'h00, "neg_00");
        do_op(3'd5, 8'h5A, 8'hA5, "xor");
        do_op(3'd4, 8'h5A, 8'hA5, "and");
        do_op(3'd2, 8'h0C, 8'h30, "or");
        do_op(3'd0, 8'h7F, 8'h01, "add_ovf");
        do_op(3'd6, 8'h0F, 8'h11, "mul_0f_11");
        do_op(3'd6, 8'h10, 8'h10, "mul_10_10");
        do_op(3'd6, 8'hFF, 8'hFF, "mul_ff_ff");

        // Backpressure: hold the result while a new request waits.
        start(3'd0, 8'h33, 8'h44, "bp_first");
        @(negedge clk);
        in_valid = 1'b0;
        wait_result();
        start(3'd2, 8'h0F, 8'h30, "bp_second");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_res", 32'(res), 32'h77);
            chk("bp_hold_flags", {29'd0, carry, overflow, zero}, 32'h0);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result();
        consume();

        // Accumulate chain.
        do_op(3'd0, 8'h0A, 8'h06, "acc_seed");
        do_op(3'd7, 8'h05, 8'h00, "acc_add05");
        do_op(3'd7, 8'hF0, 8'h00, "acc_wrap");

        // Reset in the middle of a multiply.
        start(3'd6, 8'h0F, 8'h11, "mul_aborted");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_res", 32'(res), 32'h0);
        chk("midrst_flags", {29'd0, carry, overflow, zero}, 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_seven", 32'(seven_output), 32'h3F);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        m_acc = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3'd7, 8'h03, 8'h00, "acc_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
